// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters, a sequential
// flush engine and a saturating mispredict counter. Lookup is purely combinational.
module branch_predictor #(
    parameter int IW      = 32,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int MCNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IW-1:0]     i_lookup_pc,
    output logic              o_pred_hit,
    output logic              o_pred_taken,
    output logic [IW-1:0]     o_pred_target,
    input  logic              i_upd_valid,
    input  logic [IW-1:0]     i_upd_pc,
    input  logic              i_upd_taken,
    input  logic [IW-1:0]     i_upd_target,
    input  logic              i_upd_mispred,
    input  logic              i_flush,
    output logic              o_busy,
    output logic [MCNT_W-1:0] o_mispred_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = IW - IDX_W - 2;
    localparam logic [CTR_W-1:0] WT  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] WNT = {1'b0, {(CTR_W-1){1'b1}}};

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [MCNT_W-1:0]  cnt_q, cnt_d;
    logic               valid_q [ENTRIES];
    logic               valid_d [ENTRIES];
    logic [TAG_W-1:0]   tag_q   [ENTRIES];
    logic [TAG_W-1:0]   tag_d   [ENTRIES];
    logic [IW-1:0]      tgt_q   [ENTRIES];
    logic [IW-1:0]      tgt_d   [ENTRIES];
    logic [CTR_W-1:0]   ctr_q   [ENTRIES];
    logic [CTR_W-1:0]   ctr_d   [ENTRIES];

    logic [IDX_W-1:0]   lk_idx, upd_idx;
    logic [TAG_W-1:0]   lk_tag, upd_tag;
    logic               upd_acc, upd_hit;
    logic               upd_pc_unused;

    assign lk_idx        = i_lookup_pc[IDX_W+1:2];
    assign lk_tag        = i_lookup_pc[IW-1:IDX_W+2];
    assign upd_idx       = i_upd_pc[IDX_W+1:2];
    assign upd_tag       = i_upd_pc[IW-1:IDX_W+2];
    assign upd_pc_unused = ^i_upd_pc[1:0];

    assign o_busy        = (state_q == S_FLUSH);
    assign o_mispred_cnt = cnt_q;

    // A pending flush request takes priority over a coincident table update.
    assign upd_acc = i_upd_valid & ~o_busy & ~i_flush;
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        o_pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !o_busy;
        o_pred_taken  = o_pred_hit && ctr_q[lk_idx][CTR_W-1];
        o_pred_target = o_pred_taken ? tgt_q[lk_idx] : i_lookup_pc + IW'(4);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (i_flush) begin
                    state_d = S_FLUSH;
                    ptr_d   = '0;
                end
            end
            S_FLUSH: begin
                valid_d[ptr_q] = 1'b0;
                ptr_d          = ptr_q + 1'b1;
                if (ptr_q == {IDX_W{1'b1}}) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (upd_acc) begin
            if (upd_hit) begin
                if (i_upd_taken) begin
                    if (ctr_q[upd_idx] != {CTR_W{1'b1}}) ctr_d[upd_idx] = ctr_q[upd_idx] + 1'b1;
                    tgt_d[upd_idx] = i_upd_target;
                end else if (ctr_q[upd_idx] != '0) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 1'b1;
                end
            end else if (i_upd_taken) begin
                valid_d[upd_idx] = 1'b1;
                tag_d[upd_idx]   = upd_tag;
                tgt_d[upd_idx]   = i_upd_target;
                ctr_d[upd_idx]   = WT;
            end
        end

        // Mispredicts are counted even when the table update itself is dropped.
        if (i_upd_valid && i_upd_mispred && (cnt_q != {MCNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= WNT;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus pushes expected values into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;
    logic        clk;
    logic        reset;
    logic [31:0] i_lookup_pc;
    logic        o_pred_hit;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_upd_valid;
    logic [31:0] i_upd_pc;
    logic        i_upd_taken;
    logic [31:0] i_upd_target;
    logic        i_upd_mispred;
    logic        i_flush;
    logic        o_busy;
    logic [3:0]  o_mispred_cnt;

    branch_predictor #(.IW(32), .ENTRIES(64), .CTR_W(2), .MCNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .i_lookup_pc(i_lookup_pc), .o_pred_hit(o_pred_hit), .o_pred_taken(o_pred_taken),
        .o_pred_target(o_pred_target), .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc),
        .i_upd_taken(i_upd_taken), .i_upd_target(i_upd_target), .i_upd_mispred(i_upd_mispred),
        .i_flush(i_flush), .o_busy(o_busy), .o_mispred_cnt(o_mispred_cnt)
    );

    typedef struct {
        string       name;
        int          kind;  // 0 hit, 1 taken, 2 target, 3 busy, 4 mispredict count
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] act;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          wait_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                0:       act = {31'b0, o_pred_hit};
                1:       act = {31'b0, o_pred_taken};
                2:       act = o_pred_target;
                3:       act = {31'b0, o_busy};
                default: act = {28'b0, o_mispred_cnt};
            endcase
            n_tests++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int kind, input logic [31:0] v);
        exp_t x;
        x.name = nm;
        x.kind = kind;
        x.val  = v;
        q.push_back(x);
    endtask

    task automatic now_chk(input string nm, input logic [31:0] got, input logic [31:0] v);
        n_tests++;
        if (got !== v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, v);
        end
    endtask

    task automatic push_look(input string nm, input logic [31:0] pc, input bit h, input bit t,
                             input logic [31:0] tg);
        i_lookup_pc = pc;
        chk({nm, "_hit"}, 0, {31'b0, h});
        chk({nm, "_taken"}, 1, {31'b0, t});
        chk({nm, "_tgt"}, 2, tg);
    endtask

    task automatic look(input string nm, input logic [31:0] pc, input bit h, input bit t,
                        input logic [31:0] tg);
        push_look(nm, pc, h, t, tg);
        step();
    endtask

    task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg, input bit mp);
        i_upd_pc      = pc;
        i_upd_taken   = tk;
        i_upd_target  = tg;
        i_upd_mispred = mp;
        i_upd_valid   = 1'b1;
        tick();
        i_upd_valid   = 1'b0;
        i_upd_mispred = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        i_lookup_pc = 32'h0; i_upd_valid = 1'b0; i_upd_pc = 32'h0; i_upd_taken = 1'b0;
        i_upd_target = 32'h0; i_upd_mispred = 1'b0; i_flush = 1'b0;
        tick(); tick(); tick();

        // 1: reset state and sequential-PC wrap
        i_lookup_pc = 32'h100;
        #1;
        now_chk("rst_now_busy", {31'b0, o_busy}, 32'd0);
        now_chk("rst_now_cnt", {28'b0, o_mispred_cnt}, 32'd0);
        now_chk("rst_now_hit", {31'b0, o_pred_hit}, 32'd0);
        now_chk("rst_now_taken", {31'b0, o_pred_taken}, 32'd0);
        now_chk("rst_now_tgt", o_pred_target, 32'h104);
        push_look("rst_in", 32'h100, 1'b0, 1'b0, 32'h104);
        step();
        reset = 1'b1;
        chk("rst_busy", 3, 32'd0);
        chk("rst_cnt", 4, 32'd0);
        look("t1_a", 32'h100, 1'b0, 1'b0, 32'h104);
        look("t1_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // 2: allocate then weaken
        upd(32'h100, 1'b1, 32'h80, 1'b0);
        look("t2_alloc", 32'h100, 1'b1, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 32'h999, 1'b0);
        look("t2_nt", 32'h100, 1'b1, 1'b0, 32'h104);

        // 3: saturation both ways (ctr 1 -> 3 -> 2 -> 0 -> 0 -> 1 -> 2)
        repeat (3) upd(32'h100, 1'b1, 32'h80, 1'b0);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        look("t3_sat_hi", 32'h100, 1'b1, 1'b1, 32'h80);
        repeat (2) upd(32'h100, 1'b0, 32'h0, 1'b0);
        look("t3_ctr0", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        look("t3_sat_lo", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h80, 1'b0);
        look("t3_ctr1", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h80, 1'b0);
        look("t3_ctr2", 32'h100, 1'b1, 1'b1, 32'h80);

        // 4: aliasing at index 0
        look("t4_alias_miss", 32'h200, 1'b0, 1'b0, 32'h204);
        upd(32'h200, 1'b1, 32'h40, 1'b0);
        look("t4_new", 32'h200, 1'b1, 1'b1, 32'h40);
        look("t4_old", 32'h100, 1'b0, 1'b0, 32'h104);
        upd(32'h300, 1'b0, 32'h55, 1'b0);
        look("t4_nt_noalloc", 32'h300, 1'b0, 1'b0, 32'h304);
        look("t4_keep", 32'h200, 1'b1, 1'b1, 32'h40);

        // 5: flush timing, masking and dropped updates
        upd(32'h104, 1'b1, 32'h11, 1'b0);
        upd(32'h108, 1'b1, 32'h22, 1'b0);
        upd(32'h10C, 1'b1, 32'h33, 1'b0);
        look("t5_pre", 32'h10C, 1'b1, 1'b1, 32'h33);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        for (int k = 0; k < 66; k++) begin
            i_flush = (k == 5);
            if (k == 2 || k == 40) begin
                i_upd_pc     = (k == 2) ? 32'h300 : 32'h304;
                i_upd_taken  = 1'b1;
                i_upd_target = 32'h77;
                i_upd_valid  = 1'b1;
            end else begin
                i_upd_valid = 1'b0;
            end
            if (k == 3 || k == 20) begin
                i_lookup_pc = 32'h108;
                chk($sformatf("t5_busy_look_c%0d", k), 0, 32'd0);
            end
            chk($sformatf("t5_busy_c%0d", k), 3, (k < 64) ? 32'd1 : 32'd0);
            step();
        end
        i_flush = 1'b0;
        i_upd_valid = 1'b0;
        look("t5_e0", 32'h200, 1'b0, 1'b0, 32'h204);
        look("t5_e1", 32'h104, 1'b0, 1'b0, 32'h108);
        look("t5_e2", 32'h108, 1'b0, 1'b0, 32'h10C);
        look("t5_e3", 32'h10C, 1'b0, 1'b0, 32'h110);
        look("t5_upd_drop_a", 32'h300, 1'b0, 1'b0, 32'h304);
        look("t5_upd_drop_b", 32'h304, 1'b0, 1'b0, 32'h308);

        // 6: reset during flush, mispredict counter saturation
        upd(32'h104, 1'b1, 32'h11, 1'b0);
        look("t6_pre", 32'h104, 1'b1, 1'b1, 32'h11);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        repeat (10) step();
        reset = 1'b0;
        #1;
        now_chk("t6_rst_busy_now", {31'b0, o_busy}, 32'd0);
        chk("t6_rst_busy", 3, 32'd0);
        push_look("t6_rst_look", 32'h104, 1'b0, 1'b0, 32'h108);
        step();
        step();
        reset = 1'b1;
        look("t6_after", 32'h104, 1'b0, 1'b0, 32'h108);
        chk("t6_fsm_idle", 3, 32'd0);
        step();
        repeat (5) upd(32'h500, 1'b0, 32'h0, 1'b1);
        chk("t6_cnt5", 4, 32'd5);
        step();
        i_flush = 1'b1;
        upd(32'h500, 1'b0, 32'h0, 1'b1);
        i_flush = 1'b0;
        repeat (14) upd(32'h500, 1'b0, 32'h0, 1'b1);
        chk("t6_busy_during", 3, 32'd1);
        chk("t6_cnt_sat", 4, 32'd15);
        step();
        upd(32'h500, 1'b0, 32'h0, 1'b0);
        chk("t6_cnt_nomis", 4, 32'd15);
        step();
        wait_cnt = 0;
        while (o_busy === 1'b1 && wait_cnt < 100) begin
            step();
            wait_cnt++;
        end
        n_tests++;
        if (wait_cnt >= 100) begin
            n_fail++;
            $display("FAIL t6_busy_wait: o_busy still high after %0d cycles", wait_cnt);
        end
        reset = 1'b0;
        chk("t6_cnt_rst", 4, 32'd0);
        step();
        reset = 1'b1;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
